// File: rtl/lzc_pkg.sv
// lzc_pkg: shared state encoding and nibble-count helper for the iterative leading-zero counter.
package lzc_pkg;

    typedef enum logic [1:0] {LZC_IDLE, LZC_SCAN, LZC_DONE} lzc_state_t;

    function automatic int lzc_nibbles(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/sub_zeros_detector.sv
// sub_zeros_detector: leading-zero count of a single nibble plus an all-zero flag.
module sub_zeros_detector (
    input  logic [3:0] nibble_i,
    output logic [1:0] zeros_o,
    output logic       all_zeros_o
);

    always_comb begin
        all_zeros_o = (nibble_i == 4'h0);
        zeros_o     = nibble_i[3] ? 2'd0 : nibble_i[2] ? 2'd1 : nibble_i[1] ? 2'd2 : 2'd3;
    end

endmodule

// File: rtl/iterative_zeros_counter.sv
// iterative_zeros_counter: counts leading zeros one nibble per cycle, MSB first,
// reusing a single 4-bit detector; valid/ready on both sides.
module iterative_zeros_counter
    import lzc_pkg::*;
#(
    parameter int WIDTH = 24,
    localparam int NIBBLES = lzc_nibbles(WIDTH),
    localparam int ZW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ZW-1:0]    zeros,
    output logic             all_zeros
);

    localparam int PW = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    lzc_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] operand_q, operand_d;
    logic [ZW-1:0] zeros_q, zeros_d;
    logic          all_zeros_q, all_zeros_d;
    logic [PW-1:0] shifted;
    logic [1:0]    det_zeros;
    logic          det_all_zeros;

    // Operand is left-aligned so nibble 0 is always the top nibble of the shifted view.
    assign shifted = operand_q << {idx_q, 2'b00};

    sub_zeros_detector u_det (
        .nibble_i    (shifted[PW-1 -: 4]),
        .zeros_o     (det_zeros),
        .all_zeros_o (det_all_zeros)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LZC_IDLE;
            idx_q       <= '0;
            operand_q   <= '0;
            zeros_q     <= '0;
            all_zeros_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            operand_q   <= operand_d;
            zeros_q     <= zeros_d;
            all_zeros_q <= all_zeros_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        operand_d   = operand_q;
        zeros_d     = zeros_q;
        all_zeros_d = all_zeros_q;
        if (flush) begin
            state_d     = LZC_IDLE;
            idx_d       = '0;
            zeros_d     = '0;
            all_zeros_d = 1'b0;
        end else begin
            case (state_q)
                LZC_IDLE: if (in_valid) begin
                    operand_d = PW'(value) << (PW - WIDTH);
                    idx_d     = '0;
                    state_d   = LZC_SCAN;
                end
                LZC_SCAN: if (!det_all_zeros) begin
                    zeros_d     = ZW'({idx_q, 2'b00}) + ZW'(det_zeros);
                    all_zeros_d = 1'b0;
                    state_d     = LZC_DONE;
                end else if (idx_q == IW'(NIBBLES - 1)) begin
                    // Padding nibbles are zero too, so force the count to WIDTH.
                    zeros_d     = ZW'(WIDTH);
                    all_zeros_d = 1'b1;
                    state_d     = LZC_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
                LZC_DONE: if (out_ready) state_d = LZC_IDLE;
                default:  state_d = LZC_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == LZC_IDLE);
    assign out_valid = (state_q == LZC_DONE);
    assign zeros     = zeros_q;
    assign all_zeros = all_zeros_q;

    a_range: assert property (@(posedge clk) disable iff (reset) out_valid |-> zeros <= ZW'(WIDTH));
    a_allz:  assert property (@(posedge clk) disable iff (reset) all_zeros |-> zeros == ZW'(WIDTH));
    a_excl:  assert property (@(posedge clk) disable iff (reset) !(in_ready && out_valid));

endmodule
